led_blink_sched: RTL and testbench
==================================

// Module: led_blink_sched
// PURPOSE
//  Round-robin scheduler sharing one front-panel LED between NSRC event sources.
//  Each source's trigger pulse is latched as pending and later shown as a blink
//  code of (index+1) blinks, followed by an inter-code gap. Sits between the
//  timecounter event strobes and the LED pin.
// PARAMETERS
//  NSRC     4         number of trigger sources (1..2**SW)
//  SW       2         width of source index output
//  CW       25        width of the shared phase counter
//  ON_CNT   4000000   clocks LED is on per blink (100 ms @ 40 MHz), >=1
//  OFF_CNT  4000000   clocks LED is off between blinks, >=1
//  GAP_CNT  16000000  clocks of extra dark time after a code, >=1
// PORTS
//  clk      in   1     system clock (40 MHz)
//  rst      in   1     synchronous reset, active-high
//  trig     in   NSRC  event strobes, synchronous to clk, any pulse length
//  enable   in   1     permits starting a new code
//  led_out  out  1     LED drive, registered
//  busy     out  1     1 while a code (incl. gap) is in progress
//  cur_src  out  SW    index of the source being shown, held after code ends
//  pend     out  NSRC  latched, not-yet-served sources
// BEHAVIOUR
//  - One clock, reset synchronous active-high. Reset: led_out=0, busy=0,
//    cur_src=0, pend=0, state=IDLE, counters=0, last_src=NSRC-1 (first grant
//    goes to source 0). During reset, trig_d<=trig (no spurious edge on release).
//  - Edge detect: rise[i] = trig[i] & ~trig_d[i]. pend[i] set on rise[i].
//    Set beats clear when both occur in the same cycle.
//  - States: IDLE, ON, OFF, GAP. busy = (state != IDLE).
//  - IDLE: if enable && |pend, grant the first pending index after last_src
//    (modulo NSRC). At that edge: state<=ON, led_out<=1, cur_src<=grant,
//    last_src<=grant, pend[grant] cleared, blink counter<=grant+1,
//    phase counter<=ON_CNT-1.
//  - ON: led_out=1. At phase 0: state<=OFF, led_out<=0, phase<=OFF_CNT-1,
//    blink counter decremented. ON lasts exactly ON_CNT clocks.
//  - OFF: led_out=0. At phase 0: if blinks>0, return to ON (phase<=ON_CNT-1);
//    else state<=GAP, phase<=GAP_CNT-1.
//  - GAP: led_out=0. At phase 0: state<=IDLE. Grant may happen on the next edge.
//  - Code length for source i: (i+1)*(ON_CNT+OFF_CNT)+GAP_CNT clocks of busy.
//  - Latency: trig sampled high at edge k -> pend set after k. led_out rises
//    after edge k+1 if idle and enabled.
//  - Retrigger of a source during its own code re-sets pend. It is served again
//    after the other pending sources in round-robin order.
//  - Multiple rises while pending collapse to one code (no counting).
//  - enable=0 only blocks new grants. The current code completes normally.
//    Pends keep accumulating.
//  - rst mid-code: all state as reset on the next edge. The code is abandoned.
// TESTING (NSRC=4, ON_CNT=3, OFF_CNT=2, GAP_CNT=5, enable=1 unless noted)
//  1. 1-clk pulse trig[0] -> led_out high 3 clks starting 2 clks after pulse
//     edge; busy 10 clks; cur_src=0; pend[0] 1 for 1 clk only.
//  2. Pulse trig[2] -> 3 blinks (3 on / 2 off each), then gap 5. busy 20 clks.
//  3. trig[3] and trig[0] same clk -> src0 code then src3 code, back to back
//     (1 idle clk between). cur_src 0 then 3.
//  4. Pulse trig[1] during src1 ON -> pend[1]=1 kept. After src1 code, src1 is
//     served again. With trig[2] also pending, order is src2 then src1.
//  5. enable=0, pulses trig[0],trig[1] -> led_out stays 0, pend=4'b0011. Set
//     enable=1 -> src0 then src1. Drop enable mid-code -> code finishes, no next.
//  6. Assert rst during ON with trig[2] held high across release ->
//     led_out=0, busy=0, pend=0 next clk. No code starts after release.

Source files
------------

// File: rtl/led_blink_sched.sv
// Round-robin scheduler that shares one LED between NSRC trigger sources.
// Each latched trigger is shown as (index+1) blinks followed by a dark gap.
module led_blink_sched #(
  parameter int NSRC    = 4,
  parameter int SW      = 2,
  parameter int CW      = 25,
  parameter int ON_CNT  = 4000000,
  parameter int OFF_CNT = 4000000,
  parameter int GAP_CNT = 16000000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NSRC-1:0] trig,
  input  logic            enable,
  output logic            led_out,
  output logic            busy,
  output logic [SW-1:0]   cur_src,
  output logic [NSRC-1:0] pend
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    OFF  = 2'd2,
    GAP  = 2'd3
  } state_t;

  localparam int BW = SW + 1;
  localparam logic [CW-1:0] ON_LOAD  = CW'(ON_CNT - 1);
  localparam logic [CW-1:0] OFF_LOAD = CW'(OFF_CNT - 1);
  localparam logic [CW-1:0] GAP_LOAD = CW'(GAP_CNT - 1);

  state_t          state_q, state_d;
  logic            led_q, led_d;
  logic [SW-1:0]   cur_src_q, cur_src_d;
  logic [SW-1:0]   last_src_q, last_src_d;
  logic [BW-1:0]   blink_q, blink_d;
  logic [CW-1:0]   phase_q, phase_d;
  logic [NSRC-1:0] pend_q, pend_d;
  logic [NSRC-1:0] trig_d_q;

  logic [NSRC-1:0] rise;
  logic [NSRC-1:0] clr;
  logic            grant_vld;
  logic [SW-1:0]   grant_idx;
  logic [SW-1:0]   scan_idx;

  // Scan from the farthest offset down so the nearest pending source after
  // last_src is the one left in grant_idx.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    scan_idx  = '0;
    for (int off = NSRC; off >= 1; off--) begin
      scan_idx = SW'((int'(last_src_q) + off) % NSRC);
      if (pend_q[scan_idx]) begin
        grant_vld = 1'b1;
        grant_idx = scan_idx;
      end
    end
  end

  always_comb begin
    rise       = trig & ~trig_d_q;
    state_d    = state_q;
    led_d      = led_q;
    cur_src_d  = cur_src_q;
    last_src_d = last_src_q;
    blink_d    = blink_q;
    phase_d    = phase_q;
    clr        = '0;
    case (state_q)
      IDLE: begin
        if (enable && grant_vld) begin
          state_d    = ON;
          led_d      = 1'b1;
          cur_src_d  = grant_idx;
          last_src_d = grant_idx;
          clr        = NSRC'(1) << grant_idx;
          blink_d    = BW'(grant_idx) + BW'(1);
          phase_d    = ON_LOAD;
        end
      end
      ON: begin
        if (phase_q == '0) begin
          state_d = OFF;
          led_d   = 1'b0;
          phase_d = OFF_LOAD;
          blink_d = blink_q - BW'(1);
        end else begin
          phase_d = phase_q - CW'(1);
        end
      end
      OFF: begin
        if (phase_q == '0) begin
          if (blink_q != '0) begin
            state_d = ON;
            led_d   = 1'b1;
            phase_d = ON_LOAD;
          end else begin
            state_d = GAP;
            phase_d = GAP_LOAD;
          end
        end else begin
          phase_d = phase_q - CW'(1);
        end
      end
      GAP: begin
        if (phase_q == '0) begin
          state_d = IDLE;
        end else begin
          phase_d = phase_q - CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        led_d   = 1'b0;
      end
    endcase
    // A fresh rise wins over the grant clearing the same bit.
    pend_d = (pend_q & ~clr) | rise;
  end

  // trig_d follows trig during reset so release never looks like an edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      led_q      <= 1'b0;
      cur_src_q  <= '0;
      last_src_q <= SW'(NSRC - 1);
      blink_q    <= '0;
      phase_q    <= '0;
      pend_q     <= '0;
      trig_d_q   <= trig;
    end else begin
      state_q    <= state_d;
      led_q      <= led_d;
      cur_src_q  <= cur_src_d;
      last_src_q <= last_src_d;
      blink_q    <= blink_d;
      phase_q    <= phase_d;
      pend_q     <= pend_d;
      trig_d_q   <= trig;
    end
  end

  assign led_out = led_q;
  assign busy    = (state_q != IDLE);
  assign cur_src = cur_src_q;
  assign pend    = pend_q;

endmodule

// File: tb/tb_led_blink_sched.sv
// Bench for led_blink_sched: a timeline model (cycles since code start) checked
// every cycle, plus literal expectations for each directed scenario.
module tb_led_blink_sched;

  localparam int NSRC = 4;
  localparam int SW   = 2;
  localparam int CW   = 8;
  localparam int ON   = 3;
  localparam int OFF  = 2;
  localparam int GAP  = 5;
  localparam int P    = ON + OFF;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            enable = 1'b1;
  logic [NSRC-1:0] trig = '0;
  logic            led_out;
  logic            busy;
  logic [SW-1:0]   cur_src;
  logic [NSRC-1:0] pend;

  led_blink_sched #(
    .NSRC(NSRC), .SW(SW), .CW(CW),
    .ON_CNT(ON), .OFF_CNT(OFF), .GAP_CNT(GAP)
  ) dut (
    .clk(clk), .rst(rst), .trig(trig), .enable(enable),
    .led_out(led_out), .busy(busy), .cur_src(cur_src), .pend(pend)
  );

  // clock / reset
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // model: a code is a fixed timeline measured from its grant edge
  bit              m_valid = 1'b0;
  bit              m_active;
  bit              m_found;
  int              m_src, m_t, m_last, m_idx;
  logic [NSRC-1:0] m_pend, m_trig_prev, m_rise;

  function automatic int code_len(input int s);
    return (s + 1) * P + GAP;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_valid     = 1'b1;
      m_active    = 1'b0;
      m_src       = 0;
      m_t         = 0;
      m_last      = NSRC - 1;
      m_pend      = '0;
      m_trig_prev = trig;
    end else begin
      m_rise      = trig & ~m_trig_prev;
      m_trig_prev = trig;
      if (m_active) begin
        m_t++;
        if (m_t == code_len(m_src)) m_active = 1'b0;
      end else if (enable && m_pend != '0) begin
        m_found = 1'b0;
        for (int off = 1; off <= NSRC; off++) begin
          m_idx = (m_last + off) % NSRC;
          if (!m_found && m_pend[m_idx]) begin
            m_found  = 1'b1;
            m_active = 1'b1;
            m_t      = 0;
            m_src    = m_idx;
            m_last   = m_idx;
            m_pend[m_idx] = 1'b0;
          end
        end
      end
      m_pend = m_pend | m_rise;
    end
  end

  function automatic bit exp_led();
    return m_active && (m_t < (m_src + 1) * P) && ((m_t % P) < ON);
  endfunction

  // per-cycle compare plus activity counters for the literal checks
  int led_cnt, busy_cnt, pend0_cnt;

  always begin
    @(posedge clk);
    #1;
    if (m_valid) begin
      chk("led_out", int'(led_out), int'(exp_led()));
      chk("busy", int'(busy), int'(m_active));
      chk("cur_src", int'(cur_src), m_src);
      chk("pend", int'(pend), int'(m_pend));
      led_cnt   += int'(led_out);
      busy_cnt  += int'(busy);
      pend0_cnt += int'(pend[0]);
    end
  end

  // driver tasks (inputs change on the falling edge)
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse(input logic [NSRC-1:0] v);
    trig = v;
    tick(1);
    trig = '0;
  endtask

  task automatic clr_cnt();
    led_cnt   = 0;
    busy_cnt  = 0;
    pend0_cnt = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(1);
  endtask

  initial begin
    clr_cnt();
    tick(3);
    chk("rst_led", int'(led_out), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_cur_src", int'(cur_src), 0);
    chk("rst_pend", int'(pend), 0);
    rst = 1'b0;
    tick(2);

    // 1: single blink for source 0
    clr_cnt();
    pulse(4'b0001);
    tick(20);
    chk("t1_led_clks", led_cnt, 3);
    chk("t1_busy_clks", busy_cnt, 10);
    chk("t1_pend0_clks", pend0_cnt, 1);
    chk("t1_cur_src", int'(cur_src), 0);

    // 2: three blinks for source 2
    clr_cnt();
    pulse(4'b0100);
    tick(30);
    chk("t2_led_clks", led_cnt, 9);
    chk("t2_busy_clks", busy_cnt, 20);
    chk("t2_cur_src", int'(cur_src), 2);

    // 3: simultaneous sources 3 and 0 from reset
    do_reset();
    clr_cnt();
    pulse(4'b1001);
    tick(5);
    chk("t3_first_src", int'(cur_src), 0);
    tick(45);
    chk("t3_second_src", int'(cur_src), 3);
    chk("t3_busy_clks", busy_cnt, 35);
    chk("t3_led_clks", led_cnt, 15);

    // 4: retrigger of source 1 during its own code, with source 2 pending
    pulse(4'b0010);
    tick(2);
    pulse(4'b0110);
    chk("t4_pend_during", int'(pend), 4'b0110);
    tick(20);
    chk("t4_src_after1", int'(cur_src), 2);
    tick(25);
    chk("t4_src_third", int'(cur_src), 1);
    tick(10);
    chk("t4_busy_end", int'(busy), 0);
    chk("t4_pend_end", int'(pend), 0);

    // 5: enable gating
    enable = 1'b0;
    clr_cnt();
    pulse(4'b0011);
    tick(10);
    chk("t5_led_blocked", led_cnt, 0);
    chk("t5_pend_accum", int'(pend), 4'b0011);
    enable = 1'b1;
    tick(3);
    chk("t5_src_first", int'(cur_src), 0);
    tick(10);
    chk("t5_src_second", int'(cur_src), 1);
    chk("t5_busy_mid", int'(busy), 1);
    enable = 1'b0;
    pulse(4'b1000);
    tick(20);
    chk("t5_busy_after", int'(busy), 0);
    chk("t5_pend_after", int'(pend), 4'b1000);
    chk("t5_src_held", int'(cur_src), 1);

    // 6: reset during ON with trig[2] held across release
    enable = 1'b1;
    tick(2);
    chk("t6_led_on", int'(led_out), 1);
    trig = 4'b0100;
    rst  = 1'b1;
    tick(1);
    chk("t6_led_rst", int'(led_out), 0);
    chk("t6_busy_rst", int'(busy), 0);
    chk("t6_pend_rst", int'(pend), 0);
    rst = 1'b0;
    clr_cnt();
    tick(5);
    trig = '0;
    tick(30);
    chk("t6_busy_clks", busy_cnt, 0);
    chk("t6_led_clks", led_cnt, 0);

    // final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
